// File: rtl/uart_frame_parser.sv
// Pulls bytes from the UART RX FIFO, parses SOF/LEN/payload/CHK frames and
// forwards each payload on a valid/ready stream only after its checksum passes.
module uart_frame_parser #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = 8'hA5,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_pending,
  output logic                  rx_req,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_parity_err,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_ok,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [15:0]           frame_cnt
);

  // IDX_W counts 0..MAX_LEN; PTR_W addresses the MAX_LEN-entry buffer.
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = $clog2(MAX_LEN);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic [1:0] ERR_LEN    = 2'd1;
  localparam logic [1:0] ERR_CHK    = 2'd2;
  localparam logic [1:0] ERR_PARITY = 2'd3;

  logic [2:0]            state;
  logic                  inflight;
  logic [2:0]            lat_cnt;
  logic                  byte_valid;
  logic [IDX_W-1:0]      len_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt;
  logic [IDX_W-1:0]      rd_q;
  logic [IDX_W-1:0]      rd_nxt;
  logic [DATA_WIDTH-1:0] chk_q;
  logic [DATA_WIDTH-1:0] buf_mem [MAX_LEN];

  // The popped byte is on rx_data exactly RD_LATENCY cycles after the request cycle.
  assign byte_valid = inflight && (lat_cnt == 3'(RD_LATENCY));
  assign idx_nxt    = idx_q + IDX_W'(1);
  assign rd_nxt     = rd_q + IDX_W'(1);

  // Fetch engine: one outstanding pop; DRAIN never fetches so the FIFO buffers input.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from the values sampled at the same clock edge.
    if (rst) begin
      rx_req   <= 1'b0;
      inflight <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      rx_req <= 1'b0;
      if (byte_valid) begin
        inflight <= 1'b0;
      end else if (inflight) begin
        lat_cnt <= lat_cnt + 3'd1;
      end else if (state != ST_DRAIN && rx_pending) begin
        rx_req   <= 1'b1;
        inflight <= 1'b1;
        lat_cnt  <= '0;
      end
    end
  end

  // NOTE: the payload buffer is deliberately not reset; every entry is written
  // before it is read because DRAIN is only reachable after LEN payload bytes.
  always_ff @(posedge clk) begin
    if (state == ST_PAYLOAD && byte_valid && !rx_parity_err)
      buf_mem[idx_q[PTR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      len_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      chk_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      frame_cnt <= '0;
    end else begin
      frame_ok  <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      case (state)
        ST_HUNT: begin
          if (byte_valid && !rx_parity_err && rx_data == SOF_BYTE)
            state <= ST_LEN;
        end
        ST_LEN: begin
          if (byte_valid) begin
            if (rx_parity_err) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= ST_HUNT;
            end else if (rx_data == '0 || int'(rx_data) > MAX_LEN) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_HUNT;
            end else begin
              len_q <= IDX_W'(rx_data);
              chk_q <= rx_data;
              idx_q <= '0;
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_valid) begin
            if (rx_parity_err) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= ST_HUNT;
            end else begin
              chk_q <= chk_q ^ rx_data;
              idx_q <= idx_nxt;
              if (idx_nxt == len_q)
                state <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (byte_valid) begin
            if (rx_parity_err) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= ST_HUNT;
            end else if (rx_data != chk_q) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= ST_HUNT;
            end else begin
              frame_ok  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              rd_q      <= '0;
              out_valid <= 1'b1;
              out_data  <= buf_mem[0];
              out_last  <= (len_q == IDX_W'(1));
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // out_data/out_last are registers, so they hold while out_ready is low.
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_HUNT;
            end else begin
              rd_q     <= rd_nxt;
              out_data <= buf_mem[rd_nxt[PTR_W-1:0]];
              out_last <= (rd_nxt == len_q - IDX_W'(1));
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule
